// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbiter feeding a single IDLE/SETUP/ACCESS bus FSM.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without PREADY.
module apb_master_arb #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              REQ_VALID,
  input  logic [1:0]              REQ_WRITE,
  input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
  output logic [1:0]              REQ_GNT,
  output logic [1:0]              RSP_VALID,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic                    RSP_ERR,
  output logic                    PSELx,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e state_q;
  logic   ptr_q;
  logic   owner_q;
  logic   winner;

  if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0] tmo_q;
`endif

  // On a tie the pointer decides; otherwise the lone requester wins.
  always_comb begin
    if (REQ_VALID == 2'b11) winner = ptr_q;
    else                    winner = REQ_VALID[1];
  end

  // Registers are one cycle ahead of the bus: StSetup drives the SETUP phase out, and
  // PENABLE distinguishes the SETUP cycle from ACCESS cycles while in StAccess.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      REQ_GNT   <= '0;
      RSP_VALID <= '0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      REQ_GNT   <= '0;
      RSP_VALID <= '0;
      unique case (state_q)
        StIdle: begin
          if (|REQ_VALID) begin
            REQ_GNT <= winner ? 2'b10 : 2'b01;
            owner_q <= winner;
            ptr_q   <= ~winner;
            PWRITE  <= REQ_WRITE[winner];
            PADDR   <= winner ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : REQ_ADDR[ADDR_WIDTH-1:0];
            PWDATA  <= winner ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : REQ_WDATA[DATA_WIDTH-1:0];
            state_q <= StSetup;
          end
        end
        StSetup: begin
          PSELx   <= 1'b1;
          PENABLE <= 1'b0;
`ifdef APB_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= StAccess;
        end
        StAccess: begin
          if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            RSP_VALID <= owner_q ? 2'b10 : 2'b01;
            RSP_ERR   <= PSLVERR;
            RSP_RDATA <= PWRITE ? '0 : PRDATA;
            state_q   <= StIdle;
`ifdef APB_TIMEOUT_EN
          end else if (tmo_q == TmoLast) begin
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            RSP_VALID <= owner_q ? 2'b10 : 2'b01;
            RSP_ERR   <= 1'b1;
            RSP_RDATA <= '0;
            state_q   <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: stimulus pushes expected grants, SETUP contents and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_apb_master_arb;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 16;

  logic            PCLK;
  logic            PRESETn;
  logic [1:0]      REQ_VALID, REQ_WRITE;
  logic [2*AW-1:0] REQ_ADDR;
  logic [2*DW-1:0] REQ_WDATA;
  logic [1:0]      REQ_GNT, RSP_VALID;
  logic [DW-1:0]   RSP_RDATA;
  logic            RSP_ERR, PSELx, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic            PREADY = 1'b0;
  logic [DW-1:0]   PRDATA = '0;
  logic            PSLVERR = 1'b0;

  apb_master_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_GNT(REQ_GNT), .RSP_VALID(RSP_VALID),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {logic [1:0] v; logic [31:0] rdata; logic err; int acc;} rsp_t;
  typedef struct {logic [31:0] addr; logic wr; logic [31:0] wdata;} setup_t;
  typedef struct {int waits; logic [31:0] rdata; logic err;} slv_t;

  logic [1:0] exp_gnt[$];
  setup_t     exp_setup[$];
  rsp_t       exp_rsp[$];
  slv_t       slv_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: each transfer takes the next configuration at its SETUP cycle.
  slv_t cur_slv = '{0, 32'h0, 1'b0};
  int   scnt = 0;
  always @(posedge PCLK) begin
    #1;
    if (PSELx && !PENABLE) begin
      if (slv_q.size() > 0) cur_slv = slv_q.pop_front();
      else                  cur_slv = '{0, 32'h0, 1'b0};
      scnt = 0;
      PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    end else if (PSELx && PENABLE) begin
      if (scnt >= cur_slv.waits) begin
        PREADY = 1'b1; PRDATA = cur_slv.rdata; PSLVERR = cur_slv.err;
      end else begin
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
      end
      scnt++;
    end else begin
      PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    end
  end

  // Monitor
  int         cyc, gnt_cyc, acc_cnt;
  logic       have_gnt, prev_acc, last_err;
  logic [31:0] last_rdata;
  setup_t     cur_setup;
  setup_t     ms;
  rsp_t       mr;
  logic [1:0] mg;

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      cyc = 0; gnt_cyc = 0; acc_cnt = 0; have_gnt = 0; prev_acc = 0;
      last_rdata = '0; last_err = 0;
    end else begin
      cyc++;
      chk("gnt_onehot", 64'($onehot0(REQ_GNT)), 64'd1);
      chk("rsp_onehot", 64'($onehot0(RSP_VALID)), 64'd1);
      if (REQ_GNT != 2'b00) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(REQ_GNT), 64'd0);
        else begin
          mg = exp_gnt.pop_front();
          chk("gnt", 64'(REQ_GNT), 64'(mg));
        end
        if (have_gnt) chk("gnt_spacing_ge4", 64'((cyc - gnt_cyc) >= 4), 64'd1);
        gnt_cyc = cyc; have_gnt = 1;
      end
      if (PSELx && !PENABLE) begin
        chk("setup_latency", 64'(cyc - gnt_cyc), 64'd1);
        if (exp_setup.size() == 0) chk("setup_unexpected", 64'(PSELx), 64'd0);
        else begin
          ms = exp_setup.pop_front();
          chk("setup_paddr", 64'(PADDR), 64'(ms.addr));
          chk("setup_pwrite", 64'(PWRITE), 64'(ms.wr));
          chk("setup_pwdata", 64'(PWDATA), 64'(ms.wdata));
          cur_setup = ms;
        end
        acc_cnt = 0;
      end
      if (PSELx && PENABLE) begin
        if (acc_cnt == 0) chk("access_latency", 64'(cyc - gnt_cyc), 64'd2);
        chk("access_paddr_stable", 64'(PADDR), 64'(cur_setup.addr));
        chk("access_pwrite_stable", 64'(PWRITE), 64'(cur_setup.wr));
        chk("access_pwdata_stable", 64'(PWDATA), 64'(cur_setup.wdata));
        acc_cnt++;
      end
      if (RSP_VALID != 2'b00) begin
        chk("rsp_after_access", 64'(prev_acc), 64'd1);
        chk("rsp_bus_idle", 64'({PSELx, PENABLE}), 64'd0);
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'(RSP_VALID), 64'd0);
        else begin
          mr = exp_rsp.pop_front();
          chk("rsp_valid", 64'(RSP_VALID), 64'(mr.v));
          chk("rsp_rdata", 64'(RSP_RDATA), 64'(mr.rdata));
          chk("rsp_err", 64'(RSP_ERR), 64'(mr.err));
          chk("access_cycles", 64'(acc_cnt), 64'(mr.acc));
          last_rdata = mr.rdata; last_err = mr.err;
        end
      end else begin
        chk("rdata_hold", 64'(RSP_RDATA), 64'(last_rdata));
        chk("err_hold", 64'(RSP_ERR), 64'(last_err));
      end
      prev_acc = PSELx && PENABLE;
    end
  end

  task automatic expect_xfer(input logic [1:0] g, input logic [31:0] a, input logic w,
                             input logic [31:0] wd, input logic [31:0] rd, input logic e,
                             input int acc, input bit rsp);
    setup_t s;
    rsp_t   r;
    s.addr = a; s.wr = w; s.wdata = wd;
    exp_gnt.push_back(g);
    exp_setup.push_back(s);
    if (rsp) begin
      r.v = g; r.rdata = rd; r.err = e; r.acc = acc;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic slave(input int waits, input logic [31:0] rd, input logic e);
    slv_t c;
    c.waits = waits; c.rdata = rd; c.err = e;
    slv_q.push_back(c);
  endtask

  task automatic drive(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d);
    REQ_WRITE[idx] = w;
    REQ_ADDR[idx*AW +: AW] = a;
    REQ_WDATA[idx*DW +: DW] = d;
    REQ_VALID[idx] = 1'b1;
  endtask

  task automatic wait_gnt(input logic [1:0] m);
    int n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while ((REQ_GNT & m) == 2'b00 && n < 40);
    chk("gnt_seen", 64'(|(REQ_GNT & m)), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_rsp.size() + exp_gnt.size() + exp_setup.size()) != 0 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    chk("drain_queues", 64'(exp_rsp.size() + exp_gnt.size() + exp_setup.size()), 64'd0);
    repeat (2) @(negedge PCLK);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 64'(REQ_GNT), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(RSP_VALID), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(RSP_RDATA), 64'd0);
    chk({tag, "_rsp_err"}, 64'(RSP_ERR), 64'd0);
    chk({tag, "_psel"}, 64'(PSELx), 64'd0);
    chk({tag, "_penable"}, 64'(PENABLE), 64'd0);
    chk({tag, "_pwrite"}, 64'(PWRITE), 64'd0);
    chk({tag, "_paddr"}, 64'(PADDR), 64'd0);
    chk({tag, "_pwdata"}, 64'(PWDATA), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    @(negedge PCLK);
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
  endtask

  initial begin
    PRESETn = 1'b0;
    REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    repeat (3) @(negedge PCLK);
    check_zero("reset");
    #2 PRESETn = 1'b1;
    @(negedge PCLK);

    // Single read from requester 0
    expect_xfer(2'b01, 32'h10, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, 1, 1'b1);
    slave(0, 32'hA5A5A5A5, 1'b0);
    drive(0, 1'b0, 32'h10, 32'h0);
    wait_gnt(2'b01); REQ_VALID = 2'b00;
    drain();

    // Write from requester 1 with three wait states; read data must come back 0
    expect_xfer(2'b10, 32'h20, 1'b1, 32'h1234, 32'h0, 1'b0, 4, 1'b1);
    slave(3, 32'hDEADBEEF, 1'b0);
    drive(1, 1'b1, 32'h20, 32'h1234);
    wait_gnt(2'b10); REQ_VALID = 2'b00;
    drain();

    // Slave error
    expect_xfer(2'b01, 32'h30, 1'b1, 32'hCAFE, 32'h0, 1'b1, 1, 1'b1);
    slave(0, 32'hFFFF, 1'b1);
    drive(0, 1'b1, 32'h30, 32'hCAFE);
    wait_gnt(2'b01); REQ_VALID = 2'b00;
    drain();

`ifdef APB_TIMEOUT_EN
    // PREADY never rises: abort after TMO access cycles with an error
    expect_xfer(2'b10, 32'h50, 1'b0, 32'h0, 32'h0, 1'b1, TMO, 1'b1);
    slave(1000, 32'h77, 1'b0);
    drive(1, 1'b0, 32'h50, 32'h0);
    wait_gnt(2'b10); REQ_VALID = 2'b00;
    drain();
`endif

    // Contention after reset: pointer starts at 0 and alternates
    pulse_reset();
    expect_xfer(2'b01, 32'h100, 1'b0, 32'h0, 32'h11, 1'b0, 1, 1'b1);
    expect_xfer(2'b10, 32'h200, 1'b0, 32'h0, 32'h22, 1'b0, 2, 1'b1);
    expect_xfer(2'b01, 32'h100, 1'b0, 32'h0, 32'h33, 1'b0, 1, 1'b1);
    slave(0, 32'h11, 1'b0);
    slave(1, 32'h22, 1'b0);
    slave(0, 32'h33, 1'b0);
    drive(0, 1'b0, 32'h100, 32'h0);
    drive(1, 1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 3; i++) wait_gnt(2'b11);
    REQ_VALID = 2'b00;
    drain();

    // Reset during ACCESS: outputs clear at once, no response, tie then goes to 0
    expect_xfer(2'b10, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    slave(100, 32'h99, 1'b0);
    drive(1, 1'b0, 32'h40, 32'h0);
    wait_gnt(2'b10); REQ_VALID = 2'b00;
    begin
      int n = 0;
      while (!(PSELx && PENABLE) && n < 20) begin
        @(negedge PCLK);
        n++;
      end
    end
    chk("abort_in_access", 64'(PSELx & PENABLE), 64'd1);
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1 check_zero("abort");
    @(negedge PCLK);
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
    expect_xfer(2'b01, 32'h100, 1'b0, 32'h0, 32'h55, 1'b0, 1, 1'b1);
    slave(0, 32'h55, 1'b0);
    drive(0, 1'b0, 32'h100, 32'h0);
    drive(1, 1'b0, 32'h200, 32'h0);
    wait_gnt(2'b11); REQ_VALID = 2'b00;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
